// File: rtl/riscv_pkg.sv
// Shared RISC-V platform types and CLINT register offsets.
package riscv_pkg;

  typedef struct packed {
    logic meip;
    logic mtip;
    logic msip;
  } interrupt_t;

  localparam int unsigned ClintMsipOff       = 'h00;
  localparam int unsigned ClintMtimecmpLoOff = 'h08;
  localparam int unsigned ClintMtimecmpHiOff = 'h0C;
  localparam int unsigned ClintMtimeLoOff    = 'h10;
  localparam int unsigned ClintMtimeHiOff    = 'h14;

  // Merge the enabled bytes of wr_data into old_word.
  function automatic logic [31:0] apply_byte_wr(input logic [31:0] old_word,
                                                input logic [31:0] wr_data,
                                                input logic [3:0]  byte_en);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) merged[b*8 +: 8] = wr_data[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sync_flops.sv
// Multi-stage synchroniser for an asynchronous level input.
module sync_flops #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clint_timer.sv
// Core-local interrupt/timer: mtime, mtimecmp, msip and synchronised external irq,
// exposed as a small MMIO register window with one-cycle registered reads.
module clint_timer
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wr_data,
  input  logic [3:0]            i_byte_wr_en,
  input  logic                  i_rd_en,
  output logic [31:0]           o_rd_data,
  input  logic                  i_ext_irq,
  output logic [63:0]           o_mtime,
  output interrupt_t            o_interrupts
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PrescW-1:0]     presc_q, presc_d;
  logic                  tick;
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic                  msip_q, msip_d;
  logic                  mtip_q, mtip_d;
  logic [31:0]           shadow_q, shadow_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic [31:0]           rd_word;
  logic                  meip_sync;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  wr_any;
  logic                  sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mtime_lo, sel_mtime_hi;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^i_addr[1:0];

  assign word_addr    = {i_addr[ADDR_WIDTH-1:2], 2'b00};
  assign wr_any       = |i_byte_wr_en;
  assign sel_msip     = (word_addr == ADDR_WIDTH'(ClintMsipOff));
  assign sel_cmp_lo   = (word_addr == ADDR_WIDTH'(ClintMtimecmpLoOff));
  assign sel_cmp_hi   = (word_addr == ADDR_WIDTH'(ClintMtimecmpHiOff));
  assign sel_mtime_lo = (word_addr == ADDR_WIDTH'(ClintMtimeLoOff));
  assign sel_mtime_hi = (word_addr == ADDR_WIDTH'(ClintMtimeHiOff));

  always_comb begin
    tick    = (presc_q == PrescW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PrescW'(1);
  end

  // An mtime write suppresses that cycle's increment; unwritten bytes keep the old value.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_any && (sel_mtime_lo || sel_mtime_hi)) begin
      if (sel_mtime_lo) mtime_d[31:0]  = apply_byte_wr(mtime_q[31:0], i_wr_data, i_byte_wr_en);
      if (sel_mtime_hi) mtime_d[63:32] = apply_byte_wr(mtime_q[63:32], i_wr_data, i_byte_wr_en);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (sel_cmp_lo) mtimecmp_d[31:0]  = apply_byte_wr(mtimecmp_q[31:0], i_wr_data, i_byte_wr_en);
    if (sel_cmp_hi) mtimecmp_d[63:32] = apply_byte_wr(mtimecmp_q[63:32], i_wr_data, i_byte_wr_en);
    if (sel_msip && i_byte_wr_en[0]) msip_d = i_wr_data[0];
    // Compare on next-state values so mtip tracks the register update without lag.
    mtip_d = (mtime_d >= mtimecmp_d);
  end

  always_comb begin
    rd_word = '0;
    if (sel_msip)     rd_word = {31'b0, msip_q};
    if (sel_cmp_lo)   rd_word = mtimecmp_q[31:0];
    if (sel_cmp_hi)   rd_word = mtimecmp_q[63:32];
    if (sel_mtime_lo) rd_word = mtime_q[31:0];
    if (sel_mtime_hi) rd_word = shadow_q;
    rd_data_d = i_rd_en ? rd_word : rd_data_q;
    shadow_d  = (i_rd_en && sel_mtime_lo) ? mtime_q[63:32] : shadow_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      shadow_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      shadow_q   <= shadow_d;
      rd_data_q  <= rd_data_d;
    end
  end

  sync_flops #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ext_irq_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_async(i_ext_irq),
    .o_sync (meip_sync)
  );

  assign o_rd_data    = rd_data_q;
  assign o_mtime      = mtime_q;
  assign o_interrupts = {meip_sync, mtip_q, msip_q};

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer; a TICK_DIV=4 copy shares the bus for prescaler checks.
module tb_clint_timer;
  import riscv_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [4:0]  i_addr;
  logic [31:0] i_wr_data;
  logic [3:0]  i_byte_wr_en;
  logic        i_rd_en;
  logic        i_ext_irq;
  logic [31:0] o_rd_data, rd_data4;
  logic [63:0] o_mtime, mtime4;
  interrupt_t  irq, irq4;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_q[$];
  logic        meip_q[$];

  clint_timer #(.ADDR_WIDTH(5), .TICK_DIV(1), .SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_wr_data(i_wr_data),
    .i_byte_wr_en(i_byte_wr_en), .i_rd_en(i_rd_en), .o_rd_data(o_rd_data),
    .i_ext_irq(i_ext_irq), .o_mtime(o_mtime), .o_interrupts(irq)
  );

  clint_timer #(.ADDR_WIDTH(5), .TICK_DIV(4), .SYNC_STAGES(2)) dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_wr_data(i_wr_data),
    .i_byte_wr_en(i_byte_wr_en), .i_rd_en(i_rd_en), .o_rd_data(rd_data4),
    .i_ext_irq(i_ext_irq), .o_mtime(mtime4), .o_interrupts(irq4)
  );

  always #5 i_clk = ~i_clk;

  // Bus tasks start at a negedge, hold for one rising edge, and return at the next negedge.
  task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
    i_addr = addr; i_wr_data = data; i_byte_wr_en = be;
    @(negedge i_clk);
    i_byte_wr_en = '0;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp);
    i_addr = addr; i_rd_en = 1'b1;
    rd_q.push_back(exp);
    @(negedge i_clk);
    i_rd_en = 1'b0;
  endtask

  task automatic rdwr(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] exp);
    i_addr = addr; i_wr_data = data; i_byte_wr_en = 4'hF; i_rd_en = 1'b1;
    rd_q.push_back(exp);
    @(negedge i_clk);
    i_byte_wr_en = '0; i_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    i_rst = 1'b1; i_addr = '0; i_wr_data = '0; i_byte_wr_en = '0; i_rd_en = 1'b0;
    i_ext_irq = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_mtime !== 64'd0 || o_rd_data !== 32'd0 || irq !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold: mtime=%h rd=%h irq=%b want 0", o_mtime, o_rd_data, irq);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (10) @(negedge i_clk);
    checks++;
    if (o_mtime !== 64'd10) begin
      errors++; $display("FAIL mtime_after_10: got %0d want 10", o_mtime);
    end
    checks++;
    if (mtime4 !== 64'd2) begin
      errors++; $display("FAIL mtime_div4_after_10: got %0d want 2", mtime4);
    end
    checks++;
    if (irq !== 3'b000) begin
      errors++; $display("FAIL irq_after_reset: got %b want 000", irq);
    end
    rd(5'h0C, 32'hFFFF_FFFF);
    e = rd_q.pop_front();
    checks++;
    if (o_rd_data !== e) begin
      errors++; $display("FAIL rd_cmp_hi_reset: got %h want %h", o_rd_data, e);
    end
    @(negedge i_clk);
    checks++;
    if (o_rd_data !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rd_hold: got %h want ffffffff", o_rd_data);
    end
    wr(5'h04, 32'h1234_5678, 4'hF);
    rd(5'h04, 32'h0);
    e = rd_q.pop_front();
    checks++;
    if (o_rd_data !== e) begin
      errors++; $display("FAIL rd_unmapped: got %h want %h", o_rd_data, e);
    end
  endtask

  task automatic test_timer_fire();
    logic [31:0] e;
    logic        fired;
    wr(5'h0C, 32'h0, 4'hF);
    wr(5'h10, 32'd5, 4'hF);
    wr(5'h08, 32'd20, 4'hF);
    checks++;
    if (o_mtime !== 64'd6 || irq.mtip !== 1'b0) begin
      errors++; $display("FAIL pre_fire: mtime=%0d mtip=%b want 6/0", o_mtime, irq.mtip);
    end
    fired = 1'b0;
    for (int i = 0; i < 40 && !fired; i++) begin
      @(negedge i_clk);
      fired = irq.mtip;
    end
    checks++;
    if (!fired || o_mtime !== 64'd20) begin
      errors++; $display("FAIL mtip_rise: fired=%b mtime=%0d want 1 at 20", fired, o_mtime);
    end
    // Read and overwrite the same register: the read sees the old value.
    rdwr(5'h08, 32'hFFFF_FFFF, 32'd20);
    e = rd_q.pop_front();
    checks++;
    if (o_rd_data !== e) begin
      errors++; $display("FAIL rd_during_wr: got %h want %h", o_rd_data, e);
    end
    checks++;
    if (irq.mtip !== 1'b0) begin
      errors++; $display("FAIL mtip_fall: got %b want 0", irq.mtip);
    end
  endtask

  task automatic test_atomic_read();
    logic [31:0] e;
    wr(5'h10, 32'hFFFF_FFFE, 4'hF);
    wr(5'h14, 32'h0, 4'hF);
    checks++;
    if (o_mtime !== 64'h0000_0000_FFFF_FFFE) begin
      errors++; $display("FAIL mtime_hi_wr_no_inc: got %h want 00000000fffffffe", o_mtime);
    end
    @(negedge i_clk);
    rd(5'h10, 32'hFFFF_FFFF);
    e = rd_q.pop_front();
    checks++;
    if (o_rd_data !== e) begin
      errors++; $display("FAIL rd_mtime_lo: got %h want %h", o_rd_data, e);
    end
    checks++;
    if (o_mtime !== 64'h0000_0001_0000_0000) begin
      errors++; $display("FAIL mtime_carry: got %h want 0000000100000000", o_mtime);
    end
    rd(5'h14, 32'h0);
    e = rd_q.pop_front();
    checks++;
    if (o_rd_data !== e) begin
      errors++; $display("FAIL rd_mtime_hi_shadow: got %h want %h", o_rd_data, e);
    end
    rd(5'h10, 32'h1);
    rd(5'h14, 32'h1);
    e = rd_q.pop_front();
    e = rd_q.pop_front();
    checks++;
    if (o_rd_data !== e) begin
      errors++; $display("FAIL rd_mtime_hi_after_carry: got %h want %h", o_rd_data, e);
    end
  endtask

  task automatic test_prescaler_priority();
    logic [63:0] prev, expv;
    logic        changed;
    prev = mtime4;
    changed = 1'b0;
    for (int i = 0; i < 8 && !changed; i++) begin
      @(negedge i_clk);
      changed = (mtime4 !== prev);
    end
    checks++;
    if (!changed) begin
      errors++; $display("FAIL div4_no_tick: mtime4=%h stuck", mtime4);
    end
    prev = mtime4;
    repeat (3) @(negedge i_clk);
    checks++;
    if (mtime4 !== prev) begin
      errors++; $display("FAIL div4_hold: got %h want %h", mtime4, prev);
    end
    @(negedge i_clk);
    checks++;
    if (mtime4 !== prev + 64'd1) begin
      errors++; $display("FAIL div4_step: got %h want %h", mtime4, prev + 64'd1);
    end
    repeat (3) @(negedge i_clk);
    // Next rising edge is a tick for the divided copy.
    expv = {mtime4[63:8], 8'hAB};
    wr(5'h10, 32'h0000_00AB, 4'b0001);
    checks++;
    if (mtime4 !== expv) begin
      errors++; $display("FAIL byte_wr_priority: got %h want %h", mtime4, expv);
    end
    repeat (3) @(negedge i_clk);
    checks++;
    if (mtime4 !== expv) begin
      errors++; $display("FAIL presc_after_wr_hold: got %h want %h", mtime4, expv);
    end
    @(negedge i_clk);
    checks++;
    if (mtime4 !== expv + 64'd1) begin
      errors++; $display("FAIL presc_not_reset: got %h want %h", mtime4, expv + 64'd1);
    end
  endtask

  task automatic test_msip();
    logic [31:0] e;
    wr(5'h00, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (irq.msip !== 1'b1) begin
      errors++; $display("FAIL msip_set: got %b want 1", irq.msip);
    end
    rd(5'h00, 32'h1);
    e = rd_q.pop_front();
    checks++;
    if (o_rd_data !== e) begin
      errors++; $display("FAIL rd_msip: got %h want %h", o_rd_data, e);
    end
    wr(5'h00, 32'h0, 4'b0010);
    checks++;
    if (irq.msip !== 1'b1) begin
      errors++; $display("FAIL msip_byte1_wr: got %b want 1", irq.msip);
    end
    wr(5'h00, 32'h0, 4'b0001);
    checks++;
    if (irq.msip !== 1'b0) begin
      errors++; $display("FAIL msip_clear: got %b want 0", irq.msip);
    end
  endtask

  task automatic test_ext_irq();
    logic e;
    for (int k = 0; k < 12; k++) begin
      i_ext_irq = (k < 5);
      meip_q.push_back(k < 5);
      @(negedge i_clk);
      if (k >= 1) begin
        e = meip_q.pop_front();
        checks++;
        if (irq.meip !== e) begin
          errors++; $display("FAIL meip_k%0d: got %b want %b", k + 1, irq.meip, e);
        end
      end
    end
    meip_q.delete();
  endtask

  task automatic test_reset_mid_op();
    checks++;
    if (irq.mtip !== 1'b1) begin
      errors++; $display("FAIL mtip_before_reset: got %b want 1", irq.mtip);
    end
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (irq !== 3'b000 || o_mtime !== 64'd0 || mtime4 !== 64'd0 || o_rd_data !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: irq=%b mtime=%h mtime4=%h rd=%h want 0",
               irq, o_mtime, mtime4, o_rd_data);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timer_fire();
    test_atomic_read();
    test_prescaler_priority();
    test_msip();
    test_ext_irq();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
